// File: rtl/lamp_monitor.sv
// lamp_monitor: clocked lamp-health supervisor.
// Debounces N raw lamp-health lines, counts failed lamps and drives registered
// ok / alert / danger indications plus a saturating count of DANGER entries.
// Optional feature macro: LAMP_MON_LATCH_EN makes DANGER sticky until the
// operator acknowledges it while the lamps no longer classify as DANGER.
// There is no valid/ready handshake in this block: every input is a level
// sampled on each rising clock edge.
module lamp_monitor #(
    parameter int N         = 3,
    parameter int DEB       = 4,
    parameter int ALERT_TH  = 1,
    parameter int DANGER_TH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           lamp,
    input  logic                   s,
    input  logic                   ack,
    output logic                   ok,
    output logic                   alert,
    output logic                   danger,
    output logic [$clog2(N+1)-1:0] fail_cnt,
    output logic [7:0]             danger_evt,
    output logic [1:0]             dbg_state
);

    localparam int FW = $clog2(N + 1);
    localparam int CW = $clog2(DEB + 1);

    localparam logic [FW-1:0] ALERT_V  = FW'(ALERT_TH);
    localparam logic [FW-1:0] DANGER_V = FW'(DANGER_TH);
    localparam logic [FW-1:0] N_V      = FW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_ALERT  = 2'd1,
        ST_DANGER = 2'd2
    } state_t;

    logic [N-1:0]  deb;
    logic [CW-1:0] cnt [N];
    state_t        state;
    state_t        cls;
    state_t        nxt;

    // Per-channel debounce: a new level is accepted only after DEB
    // consecutive samples that all differ from the current debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '1;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (lamp[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= lamp[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Failed-lamp count straight from the debounced levels.
    always_comb begin
        fail_cnt = '0;
        for (int i = 0; i < N; i++) begin
            fail_cnt = fail_cnt + {{(FW-1){1'b0}}, ~deb[i]};
        end
    end

    // Classify the current failure count; service bypass caps it at ALERT.
    always_comb begin
        if (fail_cnt < ALERT_V) begin
            cls = ST_NORMAL;
        end else if ((fail_cnt >= DANGER_V) && !s) begin
            cls = ST_DANGER;
        end else begin
            cls = ST_ALERT;
        end
    end

`ifdef LAMP_MON_LATCH_EN
    // Sticky DANGER: leave only on an acknowledge while not classified DANGER.
    always_comb begin
        nxt = cls;
        if ((state == ST_DANGER) && !(ack && (cls != ST_DANGER))) begin
            nxt = ST_DANGER;
        end
    end
`else
    // Without latching the state simply follows the classification.
    always_comb begin
        nxt = cls;
    end

    logic unused_ack;
    assign unused_ack = ack;
`endif

    // State register with registered indications and the DANGER entry counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_NORMAL;
            ok         <= 1'b1;
            alert      <= 1'b0;
            danger     <= 1'b0;
            danger_evt <= '0;
        end else begin
            state  <= nxt;
            ok     <= (fail_cnt < N_V);
            alert  <= (nxt == ST_ALERT);
            danger <= (nxt == ST_DANGER);
            if ((nxt == ST_DANGER) && (state != ST_DANGER) &&
                (danger_evt != 8'hFF)) begin
                danger_evt <= danger_evt + 8'd1;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_lamp_monitor.sv
// Bench for lamp_monitor (N=3, DEB=4, ALERT_TH=1, DANGER_TH=2).
// Directed table of {inputs, cycles, expected outputs}, hand-written corner
// sequences, then randomized stimulus checked every cycle against a window
// based reference model. Honours LAMP_MON_LATCH_EN when defined.
module tb_lamp_monitor;

    localparam int N         = 3;
    localparam int DEB       = 4;
    localparam int ALERT_TH  = 1;
    localparam int DANGER_TH = 2;
    localparam int FW        = $clog2(N + 1);

`ifdef LAMP_MON_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  lamp;
    logic          s;
    logic          ack;
    logic          ok;
    logic          alert;
    logic          danger;
    logic [FW-1:0] fail_cnt;
    logic [7:0]    danger_evt;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    lamp_monitor #(
        .N(N), .DEB(DEB), .ALERT_TH(ALERT_TH), .DANGER_TH(DANGER_TH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lamp(lamp), .s(s), .ack(ack),
        .ok(ok), .alert(alert), .danger(danger), .fail_cnt(fail_cnt),
        .danger_evt(danger_evt), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    // A channel flips once its last DEB raw samples all disagree with it.
    logic [N-1:0] m_deb;
    logic [N-1:0] m_hist[$];
    int           m_level;   // 0 normal, 1 alert, 2 danger
    bit           m_ok;
    int           m_evt;

    function automatic void model_reset();
        m_deb = '1;
        m_hist.delete();
        m_level = 0;
        m_ok = 1'b1;
        m_evt = 0;
    endfunction

    function automatic void model_edge();
        int f;
        int c;
        int nx;
        bit all_diff;
        if (!rst_n) begin
            model_reset();
            return;
        end
        f = N - $countones(m_deb);
        if (f < ALERT_TH) c = 0;
        else if (f >= DANGER_TH && !s) c = 2;
        else c = 1;
        nx = c;
        if (LATCH && m_level == 2 && !(ack && c != 2)) nx = 2;
        if (nx == 2 && m_level != 2 && m_evt < 255) m_evt++;
        m_ok = (f < N);
        m_level = nx;
        m_hist.push_back(lamp);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        if (m_hist.size() == DEB) begin
            for (int i = 0; i < N; i++) begin
                all_diff = 1'b1;
                foreach (m_hist[j]) begin
                    if (m_hist[j][i] == m_deb[i]) all_diff = 1'b0;
                end
                if (all_diff) m_deb[i] = ~m_deb[i];
            end
        end
    endfunction

    function automatic void model_compare();
        check("mdl_fail_cnt", int'(fail_cnt), N - $countones(m_deb));
        check("mdl_ok", int'(ok), int'(m_ok));
        check("mdl_alert", int'(alert), int'(m_level == 1));
        check("mdl_danger", int'(danger), int'(m_level == 2));
        check("mdl_danger_evt", int'(danger_evt), m_evt);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        model_compare();
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_ok"}, int'(ok), 1);
        check({tag, "_alert"}, int'(alert), 0);
        check({tag, "_danger"}, int'(danger), 0);
        check({tag, "_fail_cnt"}, int'(fail_cnt), 0);
        check({tag, "_danger_evt"}, int'(danger_evt), 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [N-1:0] lamp;
        logic         s;
        logic         ack;
        int           cyc;
        logic         e_ok;
        logic         e_alert;
        logic         e_danger;
        int           e_fail;
        int           e_evt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [N-1:0] l, logic sv, logic av, int c,
                                logic eo, logic ea, logic ed, int ef, int ee);
        vec_t v;
        v.lamp = l; v.s = sv; v.ack = av; v.cyc = c;
        v.e_ok = eo; v.e_alert = ea; v.e_danger = ed; v.e_fail = ef; v.e_evt = ee;
        return v;
    endfunction

    initial begin
        int e2;
        e2 = LATCH ? 1 : 2;
        // steady healthy
        vecs.push_back(mk(3'b111, 0, 0, 5, 1, 0, 0, 0, 0));
        // lamp0 fails: fail_cnt after DEB edges, alert one edge later
        vecs.push_back(mk(3'b110, 0, 0, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(3'b110, 0, 0, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(3'b110, 0, 0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(3'b111, 0, 0, 4, 1, 1, 0, 0, 0));
        vecs.push_back(mk(3'b111, 0, 0, 1, 1, 0, 0, 0, 0));
        // 3-cycle glitch rejected
        vecs.push_back(mk(3'b101, 0, 0, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(3'b111, 0, 0, 5, 1, 0, 0, 0, 0));
        // 4-cycle pulse accepted, released four edges after restore
        vecs.push_back(mk(3'b101, 0, 0, 4, 1, 0, 0, 1, 0));
        vecs.push_back(mk(3'b111, 0, 0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(3'b111, 0, 0, 3, 1, 1, 0, 0, 0));
        vecs.push_back(mk(3'b111, 0, 0, 1, 1, 0, 0, 0, 0));
        // two lamps fail -> danger, then service bypass
        vecs.push_back(mk(3'b100, 0, 0, 4, 1, 0, 0, 2, 0));
        vecs.push_back(mk(3'b100, 0, 0, 1, 1, 0, 1, 2, 1));
        vecs.push_back(mk(3'b100, 1, 0, 1, 1, LATCH ? 0 : 1, LATCH ? 1 : 0, 2, 1));
        vecs.push_back(mk(3'b100, 0, 0, 1, 1, 0, 1, 2, e2));
        // all lamps fail -> ok drops DEB+1 edges later
        vecs.push_back(mk(3'b000, 0, 0, 4, 1, 0, 1, 3, e2));
        vecs.push_back(mk(3'b000, 0, 0, 1, 0, 0, 1, 3, e2));
        // restore: danger drops unless latched, ack releases latch
        vecs.push_back(mk(3'b111, 0, 0, 4, 0, 0, 1, 0, e2));
        vecs.push_back(mk(3'b111, 0, 0, 1, 1, 0, LATCH ? 1 : 0, 0, e2));
        vecs.push_back(mk(3'b111, 0, 1, 1, 1, 0, 0, 0, e2));
        vecs.push_back(mk(3'b111, 0, 0, 2, 1, 0, 0, 0, e2));
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        lamp  = '1;
        s     = 1'b0;
        ack   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven directed vectors
        for (int v = 0; v < vecs.size(); v++) begin
            lamp = vecs[v].lamp;
            s    = vecs[v].s;
            ack  = vecs[v].ack;
            repeat (vecs[v].cyc) tick();
            check($sformatf("vec%0d_ok", v), int'(ok), int'(vecs[v].e_ok));
            check($sformatf("vec%0d_alert", v), int'(alert), int'(vecs[v].e_alert));
            check($sformatf("vec%0d_danger", v), int'(danger), int'(vecs[v].e_danger));
            check($sformatf("vec%0d_fail_cnt", v), int'(fail_cnt), vecs[v].e_fail);
            check($sformatf("vec%0d_danger_evt", v), int'(danger_evt), vecs[v].e_evt);
        end
        ack = 1'b0;

        // ack while still classified DANGER is ignored and not remembered
        lamp = 3'b100;
        repeat (5) tick();
        check("seq_enter_danger", int'(danger), 1);
        ack = 1'b1;
        tick();
        check("seq_ack_in_danger", int'(danger), 1);
        ack = 1'b0;
        lamp = 3'b111;
        repeat (5) tick();
        check("seq_after_restore", int'(danger), LATCH ? 1 : 0);
        ack = 1'b1;
        tick();
        check("seq_ack_release", int'(danger), 0);
        check("seq_ack_release_alert", int'(alert), 0);
        ack = 1'b0;
        repeat (2) tick();

        // saturation: repeated DANGER entries through the bypass
        lamp = 3'b100;
        ack  = 1'b1;
        s    = 1'b0;
        repeat (5) tick();
        for (int k = 0; k < 300; k++) begin
            s = 1'b1;
            tick();
            s = 1'b0;
            tick();
        end
        check("sat_danger_evt", int'(danger_evt), 255);
        check("sat_danger", int'(danger), 1);

        // asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        lamp = '1;
        s    = 1'b0;
        ack  = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized stimulus against the reference model
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 5) == 0) lamp = N'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) s = ~s;
            ack = ($urandom_range(0, 3) == 0);
            if (k == 400) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_values("rand_reset");
                model_reset();
                tick();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
